// File: rtl/mem_wait_ctrl.sv
// Single-port byte-masked word memory behind a request/ready/ack handshake with
// programmable wait states and out-of-range flagging. Define MEM_PARITY_EN for per-byte parity.
//
// state   | meaning
// --------+----------------------------------------------------------------
// ST_IDLE | ready high; a request is captured (and committed here if no wait states)
// ST_WAIT | counting down wait states; access commits when the counter is 0
// ST_RESP | one-cycle ack with addr_err/data_out valid; back to idle next

module mem_wait_ctrl #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 8,
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 0,
    parameter int INIT_MEM    = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  request,
    input  logic                  we_re,
    input  logic [ADDR_W-1:0]     address,
    input  logic [DATA_W-1:0]     data_in,
    input  logic [DATA_W/8-1:0]   mask,
    output logic                  ready,
    output logic                  ack,
    output logic [DATA_W-1:0]     data_out,
`ifdef MEM_PARITY_EN
    output logic                  parity_err,
`endif
    output logic                  addr_err
);

    localparam int              NB       = DATA_W / 8;
    localparam bit              NO_WAIT  = (WAIT_STATES == 0);
    localparam logic [3:0]      CNT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
    localparam logic [ADDR_W:0] DEPTH_L  = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t              state;
    logic [3:0]          cnt;
    logic                h_we;
    logic [ADDR_W-1:0]   h_addr;
    logic [DATA_W-1:0]   h_data;
    logic [NB-1:0]       h_mask;

    logic                acc_we;
    logic [ADDR_W-1:0]   acc_addr;
    logic [DATA_W-1:0]   acc_data;
    logic [NB-1:0]       acc_mask;
    logic                commit;
    logic                in_range;
    logic [DATA_W-1:0]   rd_word;

    logic [DATA_W-1:0]   mem [DEPTH];

    // With no wait states the access commits on the capture edge, so it must
    // use the live inputs rather than the holding registers.
    always_comb begin
        if (state == ST_IDLE) begin
            acc_we   = we_re;
            acc_addr = address;
            acc_data = data_in;
            acc_mask = mask;
        end else begin
            acc_we   = h_we;
            acc_addr = h_addr;
            acc_data = h_data;
            acc_mask = h_mask;
        end
    end

    assign commit   = ((state == ST_IDLE) && request && NO_WAIT) ||
                      ((state == ST_WAIT) && (cnt == 4'd0));
    assign in_range = ({1'b0, acc_addr} < DEPTH_L);
    assign rd_word  = mem[acc_addr];

`ifdef MEM_PARITY_EN
    logic [NB-1:0] par_mem [DEPTH];
    logic          par_bad;

    always_comb begin
        par_bad = 1'b0;
        for (int i = 0; i < NB; i++) begin
            if ((^rd_word[8*i +: 8]) != par_mem[acc_addr][i]) begin
                par_bad = 1'b1;
            end
        end
    end
`endif

    // Storage is never cleared; a commit coinciding with reset is dropped.
    always_ff @(posedge clk) begin
        if (!rst && commit && acc_we && in_range) begin
            for (int i = 0; i < NB; i++) begin
                if (acc_mask[i]) begin
                    mem[acc_addr][8*i +: 8] <= acc_data[8*i +: 8];
`ifdef MEM_PARITY_EN
                    par_mem[acc_addr][i] <= ^acc_data[8*i +: 8];
`endif
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            cnt      <= 4'd0;
            ready    <= 1'b1;
            ack      <= 1'b0;
            addr_err <= 1'b0;
            data_out <= '0;
            h_we     <= 1'b0;
            h_addr   <= '0;
            h_data   <= '0;
            h_mask   <= '0;
`ifdef MEM_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            ack      <= 1'b0;
            addr_err <= 1'b0;
`ifdef MEM_PARITY_EN
            parity_err <= 1'b0;
`endif
            if (commit) begin
                ack      <= 1'b1;
                addr_err <= !in_range;
                if (!acc_we) begin
                    data_out <= in_range ? rd_word : '0;
`ifdef MEM_PARITY_EN
                    parity_err <= in_range && par_bad;
`endif
                end
            end

            case (state)
                ST_IDLE: begin
                    if (request) begin
                        h_we   <= we_re;
                        h_addr <= address;
                        h_data <= data_in;
                        h_mask <= mask;
                        ready  <= 1'b0;
                        if (NO_WAIT) begin
                            state <= ST_RESP;
                        end else begin
                            state <= ST_WAIT;
                            cnt   <= CNT_LOAD;
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt == 4'd0) begin
                        state <= ST_RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                    ready <= 1'b1;
                end
                default: begin
                    state <= ST_IDLE;
                    ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_wait_ctrl.sv
// Bench for mem_wait_ctrl: three instances (0/3/2 wait states, one with DEPTH=200)
// checked every cycle against a timestamp-based transaction model plus literal expectations.

module tb_mem_wait_ctrl;

    localparam int WS_K  [3] = '{0, 3, 2};
    localparam int DEP_K [3] = '{256, 200, 256};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst [3];
    logic        req [3];
    logic        we  [3];
    logic [7:0]  adr [3];
    logic [31:0] din [3];
    logic [3:0]  msk [3];
    logic        rdy [3];
    logic        ack [3];
    logic        aerr[3];
    logic [31:0] dout[3];
`ifdef MEM_PARITY_EN
    logic        perr[3];
`endif

    mem_wait_ctrl #(.DATA_W(32), .ADDR_W(8), .DEPTH(256), .WAIT_STATES(0), .INIT_MEM(0)) u0 (
        .clk(clk), .rst(rst[0]), .request(req[0]), .we_re(we[0]), .address(adr[0]),
        .data_in(din[0]), .mask(msk[0]), .ready(rdy[0]), .ack(ack[0]), .data_out(dout[0]),
`ifdef MEM_PARITY_EN
        .parity_err(perr[0]),
`endif
        .addr_err(aerr[0]));

    mem_wait_ctrl #(.DATA_W(32), .ADDR_W(8), .DEPTH(200), .WAIT_STATES(3), .INIT_MEM(0)) u1 (
        .clk(clk), .rst(rst[1]), .request(req[1]), .we_re(we[1]), .address(adr[1]),
        .data_in(din[1]), .mask(msk[1]), .ready(rdy[1]), .ack(ack[1]), .data_out(dout[1]),
`ifdef MEM_PARITY_EN
        .parity_err(perr[1]),
`endif
        .addr_err(aerr[1]));

    mem_wait_ctrl #(.DATA_W(32), .ADDR_W(8), .DEPTH(256), .WAIT_STATES(2), .INIT_MEM(0)) u2 (
        .clk(clk), .rst(rst[2]), .request(req[2]), .we_re(we[2]), .address(adr[2]),
        .data_in(din[2]), .mask(msk[2]), .ready(rdy[2]), .ack(ack[2]), .data_out(dout[2]),
`ifdef MEM_PARITY_EN
        .parity_err(perr[2]),
`endif
        .addr_err(aerr[2]));

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    task automatic check(string nm, int k, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s [u%0d] at cycle %0d: got %h, expected %h", nm, k, cyc, act, exp);
        end
    endtask

    // Model: an accepted request at edge n acks in the cycle after edge n+WS,
    // where the access also takes effect; the controller is busy through that cycle.
    logic [31:0] mmem [3][256];
    logic [3:0]  bad  [3][256];
    bit          busy  [3];
    int          ack_at[3];
    bit          c_we  [3];
    logic [7:0]  c_a   [3];
    logic [31:0] c_d   [3];
    logic [3:0]  c_m   [3];
    bit          e_rdy [3];
    bit          e_ack [3];
    bit          e_err [3];
    bit          e_perr[3];
    logic [31:0] e_dout[3];

    always @(posedge clk) begin
        cyc++;
        for (int k = 0; k < 3; k++) begin
            bit wr;
            bit oob;
            if (rst[k] === 1'b1) begin
                busy[k]   = 0;
                e_ack[k]  = 0;
                e_err[k]  = 0;
                e_perr[k] = 0;
                e_dout[k] = 32'h0;
            end else begin
                wr        = !busy[k];
                e_ack[k]  = 0;
                e_err[k]  = 0;
                e_perr[k] = 0;
                if (busy[k] && cyc == ack_at[k] + 1) busy[k] = 0;
                if (wr && req[k] === 1'b1) begin
                    busy[k]   = 1;
                    ack_at[k] = cyc + WS_K[k];
                    c_we[k]   = we[k];
                    c_a[k]    = adr[k];
                    c_d[k]    = din[k];
                    c_m[k]    = msk[k];
                end
                if (busy[k] && cyc == ack_at[k]) begin
                    oob      = (int'(c_a[k]) >= DEP_K[k]);
                    e_ack[k] = 1;
                    e_err[k] = oob;
                    if (c_we[k]) begin
                        if (!oob) begin
                            for (int b = 0; b < 4; b++) begin
                                if (c_m[k][b]) begin
                                    mmem[k][c_a[k]][8*b +: 8] = c_d[k][8*b +: 8];
                                    bad[k][c_a[k]][b] = 1'b0;
                                end
                            end
                        end
                    end else begin
                        e_dout[k] = oob ? 32'h0 : mmem[k][c_a[k]];
                        e_perr[k] = !oob && (bad[k][c_a[k]] != 4'h0);
                    end
                end
            end
            e_rdy[k] = !busy[k];
        end
    end

    always @(negedge clk) begin
        if (cyc >= 1) begin
            for (int k = 0; k < 3; k++) begin
                check("ready",    k, 32'(rdy[k]),  32'(e_rdy[k]));
                check("ack",      k, 32'(ack[k]),  32'(e_ack[k]));
                check("addr_err", k, 32'(aerr[k]), 32'(e_err[k]));
                check("data_out", k, dout[k],      e_dout[k]);
`ifdef MEM_PARITY_EN
                check("parity_err", k, 32'(perr[k]), 32'(e_perr[k]));
`endif
            end
        end
    end

    // Issues one transaction from an idle negedge; returns at the negedge of the ack cycle.
    task automatic txn(int k, bit w, logic [7:0] a, logic [31:0] d, logic [3:0] m, output int lat);
        int g = 0;
        while (rdy[k] !== 1'b1 && g < 50) begin
            @(negedge clk);
            g++;
        end
        req[k] = 1'b1; we[k] = w; adr[k] = a; din[k] = d; msk[k] = m;
        @(negedge clk);
        req[k] = 1'b0;
        lat = 1;
        while (ack[k] !== 1'b1 && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        if (ack[k] !== 1'b1) begin
            n_cmp++;
            n_bad++;
            $display("FAIL ack_timeout [u%0d]: got no ack, expected ack within 50 cycles", k);
        end
    endtask

    initial begin
        int lat;
        int acks;
        for (int k = 0; k < 3; k++) begin
            rst[k] = 1'b1; req[k] = 1'b0; we[k] = 1'b0;
            adr[k] = 8'h0; din[k] = 32'h0; msk[k] = 4'h0;
        end
        repeat (2) @(negedge clk);
        check("reset_ready", 0, 32'(rdy[0]), 32'd1);
        check("reset_dout",  0, dout[0],     32'h0);
        for (int k = 0; k < 3; k++) rst[k] = 1'b0;
        @(negedge clk);

        // zero wait states
        txn(0, 1, 8'h10, 32'hDEADBEEF, 4'hF, lat);
        check("ws0_write_lat", 0, 32'(lat), 32'd1);
        txn(0, 0, 8'h10, 32'h0, 4'h0, lat);
        check("ws0_read_lat",  0, 32'(lat), 32'd1);
        check("ws0_read_data", 0, dout[0], 32'hDEADBEEF);
        check("ws0_read_err",  0, 32'(aerr[0]), 32'd0);

        // byte masking, then an empty mask
        txn(0, 1, 8'h05, 32'h11223344, 4'hF, lat);
        txn(0, 1, 8'h05, 32'hAABBCCDD, 4'b0101, lat);
        txn(0, 0, 8'h05, 32'h0, 4'h0, lat);
        check("mask_merge", 0, dout[0], 32'h11BB33DD);
        txn(0, 1, 8'h05, 32'hFFFFFFFF, 4'h0, lat);
        txn(0, 0, 8'h05, 32'h0, 4'hF, lat);
        check("mask_zero", 0, dout[0], 32'h11BB33DD);
        txn(0, 1, 8'hFF, 32'h01020304, 4'b1001, lat);
        txn(0, 0, 8'hFF, 32'h0, 4'h0, lat);
        check("top_addr_err", 0, 32'(aerr[0]), 32'd0);

        // three wait states, DEPTH=200
        txn(1, 1, 8'h48, 32'h55AA55AA, 4'hF, lat);
        check("ws3_write_lat", 1, 32'(lat), 32'd4);
        txn(1, 0, 8'h48, 32'h0, 4'h0, lat);
        check("ws3_read_data", 1, dout[1], 32'h55AA55AA);
        txn(1, 1, 8'hC8, 32'h12345678, 4'hF, lat);
        check("oob_write_err", 1, 32'(aerr[1]), 32'd1);
        txn(1, 0, 8'hC8, 32'h0, 4'h0, lat);
        check("oob_read_err",  1, 32'(aerr[1]), 32'd1);
        check("oob_read_data", 1, dout[1], 32'h0);
        txn(1, 0, 8'h48, 32'h0, 4'h0, lat);
        check("alias_intact",  1, dout[1], 32'h55AA55AA);
        txn(1, 0, 8'hC7, 32'h0, 4'h0, lat);
        check("last_in_range_err", 1, 32'(aerr[1]), 32'd0);

        // request held high through busy cycles counts once
        @(negedge clk);
        req[1] = 1'b1; we[1] = 1'b0; adr[1] = 8'h48; msk[1] = 4'h0;
        acks = 0;
        lat  = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (i == 2) req[1] = 1'b0;
            if (ack[1] === 1'b1) begin
                acks++;
                if (lat == 0) lat = i + 1;
            end
        end
        check("busy_req_acks", 1, 32'(acks), 32'd1);
        check("busy_req_lat",  1, 32'(lat),  32'd4);

        // reset while a write waits
        txn(2, 1, 8'h20, 32'h0BADBEEF, 4'hF, lat);
        check("ws2_write_lat", 2, 32'(lat), 32'd3);
        @(negedge clk);
        req[2] = 1'b1; we[2] = 1'b1; adr[2] = 8'h20; din[2] = 32'hCAFEF00D; msk[2] = 4'hF;
        @(negedge clk);
        req[2] = 1'b0;
        rst[2] = 1'b1;
        @(negedge clk);
        rst[2] = 1'b0;
        check("ready_after_rst", 2, 32'(rdy[2]), 32'd1);
        acks = 0;
        for (int i = 0; i < 6; i++) begin
            if (ack[2] === 1'b1) acks++;
            @(negedge clk);
        end
        check("aborted_no_ack", 2, 32'(acks), 32'd0);
        txn(2, 0, 8'h20, 32'h0, 4'h0, lat);
        check("aborted_write_dropped", 2, dout[2], 32'h0BADBEEF);

`ifdef MEM_PARITY_EN
        txn(0, 1, 8'h30, 32'h0F0F0F0F, 4'hF, lat);
        @(negedge clk);
        u0.mem[8'h30][0] = ~u0.mem[8'h30][0];
        mmem[0][8'h30][0] = ~mmem[0][8'h30][0];
        bad[0][8'h30][0] = 1'b1;
        txn(0, 0, 8'h30, 32'h0, 4'h0, lat);
        check("parity_flip", 0, 32'(perr[0]), 32'd1);
        txn(0, 0, 8'h10, 32'h0, 4'h0, lat);
        check("parity_clean", 0, 32'(perr[0]), 32'd0);
`endif

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
